// File: rtl/conv_1x1_accum_02.sv
// Channel accumulator for the 1x1 convolution datapath: sums CHANNEL_NUM_IN
// fp32 products per output pixel, optional ReLU, and flags the last pixel of a frame.
module conv_1x1_accum_02 #(
    parameter int DATA_WIDTH      = 32,
    parameter int CHANNEL_NUM_IN  = 128,
    parameter int CHANNEL_NUM_OUT = 256,
    parameter int IMAGE_WIDTH     = 32,
    parameter int IMAGE_HEIGHT    = 32,
    parameter int RELU            = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int PIX_TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM_OUT;
    localparam int CW = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
    localparam int PW = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;
    localparam logic [CW-1:0] CH_LAST  = CW'(CHANNEL_NUM_IN - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_TOTAL - 1);
    localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

    // fp32 add, round-to-nearest-even, denormals flushed to signed zero
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic               sa, sb, sl, swap;
        logic [7:0]         ea, eb, el, es, d;
        logic [22:0]        fa, fb, fl, fs, mant;
        logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, rup;
        logic [49:0]        sh;
        logic [26:0]        lm, sm, mn;
        logic [27:0]        sum;
        logic [4:0]         lz;
        logic [24:0]        rnd;
        logic signed [9:0]  ex;
        logic [31:0]        r;
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31]; eb = b[30:23]; fb = b[22:0];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (fa == 23'h0);
        b_inf  = (eb == 8'hFF) && (fb == 23'h0);
        a_nan  = (ea == 8'hFF) && (fa != 23'h0);
        b_nan  = (eb == 8'hFF) && (fb != 23'h0);
        swap = {eb, fb} > {ea, fa};
        sl = swap ? sb : sa;
        el = swap ? eb : ea;
        fl = swap ? fb : fa;
        es = swap ? ea : eb;
        fs = swap ? fa : fb;
        d  = el - es;
        sh = {1'b1, fs, 26'h0} >> d;
        sm = sh[49:23] | {26'h0, (|sh[22:0]) | (d > 8'd49)};
        lm = {1'b1, fl, 3'b000};
        if (sa == sb) begin
            sum = {1'b0, lm} + {1'b0, sm};
        end else begin
            sum = {1'b0, lm} - {1'b0, sm};
        end
        ex = $signed({2'b00, el});
        lz = 5'd0;
        mn = '0;
        if (sum[27]) begin
            mn = {sum[27:2], sum[1] | sum[0]};
            ex = ex + 10'sd1;
        end else begin
            for (int i = 0; i < 27; i++) begin
                if (sum[i]) lz = 5'(26 - i);
            end
            mn = sum[26:0] << lz;
            ex = ex - $signed({5'b00000, lz});
        end
        rup  = mn[2] && (mn[1] || mn[0] || mn[3]);
        rnd  = {2'b01, mn[25:3]} + 25'(rup);
        mant = rnd[24] ? 23'h0 : rnd[22:0];
        if (rnd[24]) ex = ex + 10'sd1;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            r = QNAN;
        end else if (a_inf) begin
            r = {sa, 8'hFF, 23'h0};
        end else if (b_inf) begin
            r = {sb, 8'hFF, 23'h0};
        end else if (a_zero && b_zero) begin
            r = {sa & sb, 31'h0};
        end else if (a_zero) begin
            r = b;
        end else if (b_zero) begin
            r = a;
        end else if (sum == 28'h0) begin
            r = 32'h0;
        end else if (ex >= 10'sd255) begin
            r = {sl, 8'hFF, 23'h0};
        end else if (ex <= 10'sd0) begin
            r = {sl, 31'h0};
        end else begin
            r = {sl, ex[7:0], mant};
        end
        return r;
    endfunction

    logic [31:0]   acc_q, acc_d;
    logic [CW-1:0] ch_cnt_q, ch_cnt_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [31:0]   pxl_out_q, pxl_out_d;
    logic          valid_out_q, valid_out_d;
    logic          frame_done_q, frame_done_d;
    logic [31:0]   res;
    logic          ch_first, ch_last, res_neg;

    always_comb begin
        ch_first = (ch_cnt_q == '0);
        ch_last  = (ch_cnt_q == CH_LAST);
        res      = ch_first ? pxl_in : fp_add(acc_q, pxl_in);
        res_neg  = res[31] && !((res[30:23] == 8'hFF) && (res[22:0] != 23'h0));
        acc_d        = acc_q;
        ch_cnt_d     = ch_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        pxl_out_d    = pxl_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        if (valid_in) begin
            acc_d    = res;
            ch_cnt_d = ch_last ? '0 : ch_cnt_q + 1'b1;
            if (ch_last) begin
                pxl_out_d    = (RELU != 0 && res_neg) ? 32'h0 : res;
                valid_out_d  = 1'b1;
                frame_done_d = (pix_cnt_q == PIX_LAST);
                pix_cnt_d    = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q        <= '0;
            ch_cnt_q     <= '0;
            pix_cnt_q    <= '0;
            pxl_out_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ch_cnt_q     <= ch_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            pxl_out_q    <= pxl_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pxl_out    = pxl_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_1x1_accum_02.sv
// Directed bench for conv_1x1_accum_02: three instances (4 ch, 4 ch + ReLU,
// 2 ch) share the stimulus; expected values are hand-computed fp32 constants.
module tb_conv_1x1_accum_02;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] pxl_in;
    logic [31:0] pa, pr, pf;
    logic        va, vr, vf, fda, fdr, fdf;

    int checks = 0;
    int failures = 0;

    int na, nr, nf, badf, orphan;
    logic [31:0] last_a, last_r;
    logic [15:0] fdm_f;

    always #5 clk = ~clk;

    conv_1x1_accum_02 #(
        .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2),
        .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .RELU(0)
    ) u_a (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .pxl_out(pa), .valid_out(va), .frame_done(fda)
    );

    conv_1x1_accum_02 #(
        .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2),
        .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .RELU(1)
    ) u_r (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .pxl_out(pr), .valid_out(vr), .frame_done(fdr)
    );

    conv_1x1_accum_02 #(
        .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2),
        .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .RELU(0)
    ) u_f (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .pxl_out(pf), .valid_out(vf), .frame_done(fdf)
    );

    always @(negedge clk) begin
        if (va) begin
            na++;
            last_a = pa;
        end
        if (vr) begin
            nr++;
            last_r = pr;
        end
        if (vf) begin
            if (pf !== 32'h4000_0000) badf++;
            if (fdf && nf < 16) fdm_f[nf] = 1'b1;
            nf++;
        end
        if (fdf && !vf) orphan++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic clr();
        na = 0; nr = 0; nf = 0; badf = 0; orphan = 0;
        last_a = 32'hFFFF_FFFF;
        last_r = 32'hFFFF_FFFF;
        fdm_f = '0;
    endtask

    task automatic send(input logic [31:0] d);
        @(negedge clk);
        valid_in = 1'b1;
        pxl_in = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            pxl_in = 32'hDEAD_BEEF;
        end
    endtask

    task automatic group(input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         input int gap);
        clr();
        send(d0); idle(gap);
        send(d1); idle(gap);
        send(d2); idle(gap);
        send(d3);
        idle(3);
    endtask

    initial begin
        reset = 1'b0;
        valid_in = 1'b0;
        pxl_in = '0;
        clr();
        repeat (3) @(negedge clk);
        check("rst_pxl", pa, 32'h0);
        check("rst_valid", {31'b0, va}, 32'h0);
        check("rst_fd", {31'b0, fda}, 32'h0);
        check("rst_pxl_relu", pr, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        clr();
        send(32'h3F80_0000);
        send(32'h4000_0000);
        send(32'h4040_0000);
        send(32'h4080_0000);
        @(negedge clk);
        valid_in = 1'b0;
        check("lat_valid", {31'b0, va}, 32'h1);
        check("lat_pxl", pa, 32'h4120_0000);
        check("lat_fd", {31'b0, fda}, 32'h0);
        @(negedge clk);
        check("hold_valid", {31'b0, va}, 32'h0);
        check("hold_pxl", pa, 32'h4120_0000);
        idle(2);
        check("lat_count", na, 1);

        for (int g = 1; g <= 3; g++) begin
            group(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, g);
            check("gap_count", na, 1);
            check("gap_pxl", last_a, 32'h4120_0000);
        end

        group(32'hBF80_0000, 32'hC000_0000, 32'hC040_0000, 32'hC080_0000, 0);
        check("neg_pxl", last_a, 32'hC120_0000);
        check("neg_relu", last_r, 32'h0);
        check("neg_relu_count", nr, 1);

        group(32'h40A0_0000, 32'hC0A0_0000, 32'h0, 32'h0, 0);
        check("cancel", last_a, 32'h0);

        group(32'h7F80_0000, 32'hFF80_0000, 32'h0, 32'h0, 1);
        check("inf_minus_inf", last_a, 32'h7FC0_0000);
        check("nan_relu", last_r, 32'h7FC0_0000);

        group(32'h0000_0001, 32'h3F80_0000, 32'h0, 32'h0, 0);
        check("denorm", last_a, 32'h3F80_0000);

        group(32'hFF7F_FFFF, 32'hFF7F_FFFF, 32'h0, 32'h0, 0);
        check("neg_overflow", last_a, 32'hFF80_0000);
        check("neg_inf_relu", last_r, 32'h0);

        group(32'h3F80_0000, 32'h3380_0000, 32'h0, 32'h0, 0);
        check("rne_tie_even", last_a, 32'h3F80_0000);
        group(32'h3F80_0001, 32'h3380_0000, 32'h0, 32'h0, 0);
        check("rne_tie_odd", last_a, 32'h3F80_0002);

        group(32'h3FC0_0000, 32'hBE80_0000, 32'h0, 32'h0, 2);
        check("mixed_sub", last_a, 32'h3FA0_0000);
        check("mixed_relu", last_r, 32'h3FA0_0000);

        clr();
        send(32'h3F80_0000);
        send(32'h3F80_0000);
        @(negedge clk);
        valid_in = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_pxl", pa, 32'h0);
        check("midrst_valid", {31'b0, va}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        group(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 0);
        check("midrst_count", na, 1);
        check("midrst_pxl_after", last_a, 32'h4120_0000);

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clr();
        for (int i = 0; i < 32; i++) send(32'h3F80_0000);
        idle(3);
        check("frame_count", nf, 16);
        check("frame_bad_val", badf, 0);
        check("frame_fd_pos", {16'h0, fdm_f}, 32'h0000_8080);
        check("frame_fd_orphan", orphan, 0);
        check("frame4_count", na, 8);
        check("frame4_pxl", last_a, 32'h4080_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
